// File: rtl/aes_inv_key_expand_128_if.sv
`default_nettype none
// =============================================================================
// Module      : aes_inv_key_expand_128_if
// Description : Key-load / round-key readback bundle for the AES-128 inverse
//               key schedule. Carries rewind when AES_INV_KEY_REWIND_EN is set.
// Revision    : 1.0 - initial release
// =============================================================================
interface aes_inv_key_expand_128_if;
    logic         kld;
    logic [127:0] key;
    logic         nxt;
    logic [31:0]  wo_0;
    logic [31:0]  wo_1;
    logic [31:0]  wo_2;
    logic [31:0]  wo_3;
    logic [3:0]   rnd;
    logic         key_rdy;
`ifdef AES_INV_KEY_REWIND_EN
    logic         rewind;

    modport master (
        output kld, key, nxt, rewind,
        input  wo_0, wo_1, wo_2, wo_3, rnd, key_rdy
    );
    modport slave (
        input  kld, key, nxt, rewind,
        output wo_0, wo_1, wo_2, wo_3, rnd, key_rdy
    );
`else
    modport master (
        output kld, key, nxt,
        input  wo_0, wo_1, wo_2, wo_3, rnd, key_rdy
    );
    modport slave (
        input  kld, key, nxt,
        output wo_0, wo_1, wo_2, wo_3, rnd, key_rdy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/aes_inv_key_expand_128.sv
`default_nettype none
// =============================================================================
// Module      : aes_inv_key_expand_128 (+ aes_sbox)
// Description : AES-128 decryption key schedule: expands forward to round 10,
//               then steps round keys back to 0 on request. Optional round-10
//               rewind selected by macro AES_INV_KEY_REWIND_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module aes_sbox (
    input  wire logic [7:0] a,
    output logic      [7:0] d
);
    localparam logic [2047:0] c_sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset of entry a is 8*(255-a).
    logic [10:0] w_off;
    assign w_off = {~a, 3'b000};
    assign d     = c_sbox_table[w_off +: 8];
endmodule

module aes_inv_key_expand_128 (
    input  wire logic              clk,
    input  wire logic              rst,
    aes_inv_key_expand_128_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_w0, r_w1, r_w2, r_w3;
    logic [31:0] w_w0_nxt, w_w1_nxt, w_w2_nxt, w_w3_nxt;
    logic [3:0]  r_rnd, w_rnd_nxt;
    logic        r_rdy, w_rdy_nxt;

    logic [31:0] w_sub_in, w_rot, w_sub, w_t;
    logic [3:0]  w_rcon_idx;
    logic [31:0] w_f0, w_f1, w_f2, w_f3;
    logic [31:0] w_b0, w_b1, w_b2, w_b3;

    function automatic logic [7:0] f_rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    f_rcon = 8'h01;
            4'd2:    f_rcon = 8'h02;
            4'd3:    f_rcon = 8'h04;
            4'd4:    f_rcon = 8'h08;
            4'd5:    f_rcon = 8'h10;
            4'd6:    f_rcon = 8'h20;
            4'd7:    f_rcon = 8'h40;
            4'd8:    f_rcon = 8'h80;
            4'd9:    f_rcon = 8'h1b;
            4'd10:   f_rcon = 8'h36;
            default: f_rcon = 8'h00;
        endcase
    endfunction

    // One S-box bank serves both directions: the inverse step needs
    // SubWord(RotWord(a3^a2)), which is exactly the new b3.
    assign w_sub_in   = (r_state == READY) ? (r_w3 ^ r_w2) : r_w3;
    assign w_rot      = {w_sub_in[23:0], w_sub_in[31:24]};
    assign w_rcon_idx = (r_state == READY) ? r_rnd : (r_rnd + 4'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .a (w_rot[8*gi +: 8]),
                .d (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign w_t  = w_sub ^ {f_rcon(w_rcon_idx), 24'h000000};

    assign w_f0 = r_w0 ^ w_t;
    assign w_f1 = r_w1 ^ w_f0;
    assign w_f2 = r_w2 ^ w_f1;
    assign w_f3 = r_w3 ^ w_f2;

    assign w_b3 = r_w3 ^ r_w2;
    assign w_b2 = r_w2 ^ r_w1;
    assign w_b1 = r_w1 ^ r_w0;
    assign w_b0 = r_w0 ^ w_t;

`ifdef AES_INV_KEY_REWIND_EN
    logic [127:0] r_save;
    logic         w_save_en;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_w0_nxt    = r_w0;
        w_w1_nxt    = r_w1;
        w_w2_nxt    = r_w2;
        w_w3_nxt    = r_w3;
        w_rnd_nxt   = r_rnd;
        w_rdy_nxt   = r_rdy;
`ifdef AES_INV_KEY_REWIND_EN
        w_save_en   = 1'b0;
`endif
        if (bus.kld) begin
            {w_w0_nxt, w_w1_nxt, w_w2_nxt, w_w3_nxt} = bus.key;
            w_rnd_nxt   = 4'd0;
            w_rdy_nxt   = 1'b0;
            w_state_nxt = EXPAND;
        end else begin
            case (r_state)
                EXPAND: begin
                    {w_w0_nxt, w_w1_nxt, w_w2_nxt, w_w3_nxt} = {w_f0, w_f1, w_f2, w_f3};
                    w_rnd_nxt = r_rnd + 4'd1;
                    if (r_rnd == 4'd9) begin
                        w_state_nxt = READY;
                        w_rdy_nxt   = 1'b1;
`ifdef AES_INV_KEY_REWIND_EN
                        w_save_en   = 1'b1;
`endif
                    end
                end
                READY: begin
`ifdef AES_INV_KEY_REWIND_EN
                    if (bus.rewind) begin
                        {w_w0_nxt, w_w1_nxt, w_w2_nxt, w_w3_nxt} = r_save;
                        w_rnd_nxt = 4'd10;
                    end else
`endif
                    if (bus.nxt && (r_rnd != 4'd0)) begin
                        {w_w0_nxt, w_w1_nxt, w_w2_nxt, w_w3_nxt} = {w_b0, w_b1, w_b2, w_b3};
                        w_rnd_nxt = r_rnd - 4'd1;
                    end
                end
                IDLE:    ;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_w0    <= 32'h0;
            r_w1    <= 32'h0;
            r_w2    <= 32'h0;
            r_w3    <= 32'h0;
            r_rnd   <= 4'd0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_w0    <= w_w0_nxt;
            r_w1    <= w_w1_nxt;
            r_w2    <= w_w2_nxt;
            r_w3    <= w_w3_nxt;
            r_rnd   <= w_rnd_nxt;
            r_rdy   <= w_rdy_nxt;
        end
    end

`ifdef AES_INV_KEY_REWIND_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_save <= 128'h0;
        end else if (w_save_en) begin
            r_save <= {w_f0, w_f1, w_f2, w_f3};
        end
    end
`endif

    assign bus.wo_0    = r_w0;
    assign bus.wo_1    = r_w1;
    assign bus.wo_2    = r_w2;
    assign bus.wo_3    = r_w3;
    assign bus.rnd     = r_rnd;
    assign bus.key_rdy = r_rdy;
endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_expand_128.sv
`default_nettype none
// Testbench for aes_inv_key_expand_128: directed FIPS-197 vectors, expected
// outputs queued by the stimulus and checked by an independent monitor.
module tb_aes_inv_key_expand_128;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_inv_key_expand_128_if bus();

    aes_inv_key_expand_128 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic         rdy;
        logic [3:0]   rnd;
        logic [127:0] w;
        logic         chk_w;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] rk [0:10];
    localparam logic [127:0] c_key2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_key2_r10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    task automatic check(input string nm, input logic [132:0] act, input logic [132:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy=%0b rnd=%0d w=%h, want rdy=%0b rnd=%0d w=%h",
                     nm, act[132], act[131:128], act[127:0], exp[132], exp[131:128], exp[127:0]);
        end
    endtask

    function automatic logic [132:0] dut_out();
        return {bus.key_rdy, bus.rnd, bus.wo_0, bus.wo_1, bus.wo_2, bus.wo_3};
    endfunction

    // Monitor: outputs settle 1 time unit after the edge that consumed a vector.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t         e;
                logic [132:0] act;
                logic [132:0] exp;
                e   = q.pop_front();
                act = dut_out();
                exp = {e.rdy, e.rnd, e.w};
                if (!e.chk_w) begin
                    act[127:0] = '0;
                    exp[127:0] = '0;
                end
                check("cycle", act, exp);
            end
        end
    end

    task automatic cyc(input logic k, input logic [127:0] kv, input logic n,
                       input logic erdy, input logic [3:0] ernd,
                       input logic [127:0] ew, input logic ecw);
        exp_t e;
        @(negedge clk);
        bus.kld = k;
        bus.key = kv;
        bus.nxt = n;
        e.rdy = erdy; e.rnd = ernd; e.w = ew; e.chk_w = ecw;
        q.push_back(e);
    endtask

    // Load the FIPS-197 key and walk the forward schedule; nxt toggles to show it is ignored.
    task automatic expand_key1();
        cyc(1'b1, rk[0], 1'b1, 1'b0, 4'd0, rk[0], 1'b1);
        for (int k = 1; k <= 9; k++)
            cyc(1'b0, '0, k[0], 1'b0, k[3:0], rk[k], 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 4'd10, rk[10], 1'b1);
    endtask

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        bus.kld = 1'b0;
        bus.key = '0;
        bus.nxt = 1'b0;
`ifdef AES_INV_KEY_REWIND_EN
        bus.rewind = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset", dut_out(), '0);
        rst = 1'b1;

        // Idle after reset: nxt does nothing
        for (int i = 0; i < 3; i++)
            cyc(1'b0, '0, i[0] ^ 1'b1, 1'b0, 4'd0, '0, 1'b1);

        // Forward expansion, then full readback 10 -> 0 and a surplus nxt
        expand_key1();
        for (int k = 9; k >= 0; k--)
            cyc(1'b0, '0, 1'b1, 1'b1, k[3:0], rk[k], 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1, 4'd0, rk[0], 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 4'd0, rk[0], 1'b1);

        // Key reload aborts an expansion in progress
        cyc(1'b1, rk[0], 1'b0, 1'b0, 4'd0, rk[0], 1'b1);
        for (int k = 1; k <= 5; k++)
            cyc(1'b0, '0, 1'b0, 1'b0, k[3:0], rk[k], 1'b1);
        cyc(1'b1, c_key2, 1'b1, 1'b0, 4'd0, c_key2, 1'b1);
        for (int k = 1; k <= 9; k++)
            cyc(1'b0, '0, 1'b0, 1'b0, k[3:0], '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 4'd10, c_key2_r10, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1, 4'd9, '0, 1'b0);

        // Asynchronous reset during readback at round 6
        expand_key1();
        for (int k = 9; k >= 6; k--)
            cyc(1'b0, '0, 1'b1, 1'b1, k[3:0], rk[k], 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", dut_out(), '0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b0, 4'd0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 4'd0, '0, 1'b1);

`ifdef AES_INV_KEY_REWIND_EN
        // Rewind beats nxt and restores round 10 without re-expansion
        expand_key1();
        for (int k = 9; k >= 3; k--)
            cyc(1'b0, '0, 1'b1, 1'b1, k[3:0], rk[k], 1'b1);
        @(negedge clk);
        bus.rewind = 1'b1;
        bus.nxt    = 1'b1;
        begin
            exp_t e;
            e.rdy = 1'b1; e.rnd = 4'd10; e.w = rk[10]; e.chk_w = 1'b1;
            q.push_back(e);
        end
        @(negedge clk);
        bus.rewind = 1'b0;
        begin
            exp_t e;
            e.rdy = 1'b1; e.rnd = 4'd9; e.w = rk[9]; e.chk_w = 1'b1;
            q.push_back(e);
        end
`endif

        @(negedge clk);
        bus.nxt = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
